// File: rtl/memlcd_spi_engine_pkg.sv
// Shared definitions for the memory-LCD serial engine.
//   - cmd_mode encodings, mode-bit positions inside the 8-bit mode field
//   - top-level state enum
//   - DUMMY_BITS: width of the per-line dummy field and the trailer
//   - max3: helper used to size the shared shift register
package memlcd_pkg;

    localparam logic [1:0] MODE_UPDATE = 2'd0;
    localparam logic [1:0] MODE_CLEAR  = 2'd1;
    localparam logic [1:0] MODE_VCOM   = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam int unsigned M0_BIT = 0;
    localparam int unsigned M1_BIT = 1;
    localparam int unsigned M2_BIT = 2;

    localparam int unsigned DUMMY_BITS = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_MODE,
        ST_ADDR,
        ST_DATA,
        ST_LDUMMY,
        ST_TRAIL,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/memlcd_spi_engine_bit_shifter.sv
// Serial bit shifter for the memory-LCD engine.
// Shifts a group of up to W bits, LSB first. Each bit lasts 2*CLK_DIV clk
// cycles: si changes as sclk falls (start of low phase), sclk rises after
// CLK_DIV cycles. When no new group is started the shifter parks sclk low.
// Ports:
//   clk, rst   system clock, async active-high reset
//   load_i     request to start a new group when ready_o is high
//   stall_i    data for the requested group is absent; hold sclk low
//   word_i     group bits (bit 0 first)
//   nbits_i    number of bits in the group (1..W)
//   ready_o    a new group may start this cycle (idle, or last cycle of last bit)
//   sclk_o     serial clock
//   si_o       serial data
module memlcd_bit_shifter
    import memlcd_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             stall_i,
    input  logic [W-1:0]     word_i,
    input  logic [CNT_W-1:0] nbits_i,
    output logic             ready_o,
    output logic             sclk_o,
    output logic             si_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic             phase_q;
    logic             active_q;
    logic             sclk_q;
    logic             si_q;
    logic [W-1:0]     sh_q;
    logic [CNT_W-1:0] bits_q;
    logic             half_end;
    logic             start;

    assign half_end = (div_q == DIV_W'(CLK_DIV - 1));
    // Ready on the final cycle of the last bit so the next group starts
    // seamlessly on the same edge that drops sclk.
    assign ready_o  = !active_q || (phase_q && half_end && (bits_q == CNT_W'(1)));
    assign start    = ready_o && load_i && !stall_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            phase_q  <= 1'b0;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            si_q     <= 1'b0;
            sh_q     <= '0;
            bits_q   <= '0;
        end else if (start) begin
            sh_q     <= word_i >> 1;
            si_q     <= word_i[0];
            bits_q   <= nbits_i;
            div_q    <= '0;
            phase_q  <= 1'b0;
            sclk_q   <= 1'b0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (half_end) begin
                div_q <= '0;
                if (!phase_q) begin
                    phase_q <= 1'b1;
                    sclk_q  <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    sclk_q  <= 1'b0;
                    if (bits_q == CNT_W'(1)) begin
                        active_q <= 1'b0;
                    end else begin
                        si_q   <= sh_q[0];
                        sh_q   <= sh_q >> 1;
                        bits_q <= bits_q - CNT_W'(1);
                    end
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign sclk_o = sclk_q;
    assign si_o   = si_q;

endmodule

// File: rtl/memlcd_spi_engine.sv
// Sharp-style memory-LCD serial engine.
// Frame: MODE(8) { ADDR(ADDR_W) DATA(LINE_PIXELS) DUMMY(8) }* TRAIL(8),
// framed by chip select with SETUP_CYC lead-in and HOLD_CYC hold/gap.
// Ports:
//   clk, rst                     system clock, async active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_mode                     0 UPDATE, 1 CLEAR, 2/3 VCOM only
//   cmd_vcom                     VCOM level (mode bit M1)
//   cmd_start_line/num_lines     first line (1-based) and count for UPDATE
//   pix_data/pix_valid/pix_ready pixel word stream, bit 0 shifted first
//   busy                         command in progress
//   underrun                     one-cycle pulse when a pixel word is late
//   lcd_sclk/lcd_si/lcd_scs      panel pins
module memlcd_spi_engine
    import memlcd_pkg::*;
#(
    parameter int unsigned LINE_PIXELS = 336,
    parameter int unsigned NUM_LINES   = 240,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SETUP_CYC   = 8,
    parameter int unsigned HOLD_CYC    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic              cmd_vcom,
    input  logic [ADDR_W-1:0] cmd_start_line,
    input  logic [ADDR_W-1:0] cmd_num_lines,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              busy,
    output logic              underrun,
    output logic              lcd_sclk,
    output logic              lcd_si,
    output logic              lcd_scs
);

    localparam int unsigned WORDS = LINE_PIXELS / DATA_W;
    localparam int unsigned SH_W  = max3(DATA_W, ADDR_W, DUMMY_BITS);
    localparam int unsigned NB_W  = $clog2(SH_W + 1);
    localparam int unsigned WL_W  = $clog2(WORDS + 1);

    state_e            state_q;
    logic [15:0]       cnt_q;
    logic              is_update_q, is_clear_q, vcom_q;
    logic [ADDR_W-1:0] addr_q, lines_left_q;
    logic [WL_W-1:0]   words_left_q;
    logic              scs_q, busy_q, rdy_q, underrun_q, stalled_q;

    logic              sh_load, sh_stall, sh_ready;
    logic [SH_W-1:0]   sh_word;
    logic [NB_W-1:0]   sh_nbits;
    logic [7:0]        mode_bits;
    logic [ADDR_W-1:0] next_addr, start_fix;
    logic              need_word, has_lines;

    assign next_addr = (addr_q >= ADDR_W'(NUM_LINES)) ? ADDR_W'(1) : addr_q + ADDR_W'(1);
    assign start_fix = ((cmd_start_line == '0) || (cmd_start_line > ADDR_W'(NUM_LINES)))
                       ? ADDR_W'(1) : cmd_start_line;
    assign has_lines = is_update_q && (lines_left_q != '0);
    // A pixel word is due at the end of the address field and at every
    // word boundary inside the line; while stalled the shifter is idle,
    // so sh_ready stays high and the request persists.
    assign need_word = sh_ready && ((state_q == ST_ADDR) ||
                                    ((state_q == ST_DATA) && (words_left_q != '0)));
    assign pix_ready = need_word && pix_valid;

    always_comb begin
        mode_bits         = '0;
        mode_bits[M0_BIT] = is_update_q;
        mode_bits[M1_BIT] = vcom_q;
        mode_bits[M2_BIT] = is_clear_q;
    end

    always_comb begin
        sh_load  = 1'b0;
        sh_stall = 1'b0;
        sh_word  = '0;
        sh_nbits = NB_W'(DUMMY_BITS);
        unique case (state_q)
            ST_SETUP: begin
                if (cnt_q == 16'(SETUP_CYC - 1)) begin
                    sh_load = 1'b1;
                    sh_word = SH_W'(mode_bits);
                end
            end
            ST_MODE: begin
                if (sh_ready) begin
                    sh_load = 1'b1;
                    if (has_lines) begin
                        sh_word  = SH_W'(addr_q);
                        sh_nbits = NB_W'(ADDR_W);
                    end
                end
            end
            ST_ADDR, ST_DATA: begin
                if (need_word) begin
                    sh_load  = 1'b1;
                    sh_stall = !pix_valid;
                    sh_word  = SH_W'(pix_data);
                    sh_nbits = NB_W'(DATA_W);
                end else if (state_q == ST_DATA && sh_ready) begin
                    sh_load = 1'b1;
                end
            end
            ST_LDUMMY: begin
                if (sh_ready) begin
                    sh_load = 1'b1;
                    if (lines_left_q != ADDR_W'(1)) begin
                        sh_word  = SH_W'(next_addr);
                        sh_nbits = NB_W'(ADDR_W);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            is_update_q  <= 1'b0;
            is_clear_q   <= 1'b0;
            vcom_q       <= 1'b0;
            addr_q       <= '0;
            lines_left_q <= '0;
            words_left_q <= '0;
            scs_q        <= 1'b0;
            busy_q       <= 1'b0;
            rdy_q        <= 1'b1;
            underrun_q   <= 1'b0;
            stalled_q    <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        is_update_q  <= (cmd_mode == MODE_UPDATE);
                        is_clear_q   <= (cmd_mode == MODE_CLEAR);
                        vcom_q       <= cmd_vcom;
                        addr_q       <= start_fix;
                        lines_left_q <= cmd_num_lines;
                        cnt_q        <= '0;
                        scs_q        <= 1'b1;
                        busy_q       <= 1'b1;
                        rdy_q        <= 1'b0;
                        state_q      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == 16'(SETUP_CYC - 1)) state_q <= ST_MODE;
                    else                             cnt_q   <= cnt_q + 16'd1;
                end
                ST_MODE: begin
                    if (sh_ready) state_q <= has_lines ? ST_ADDR : ST_TRAIL;
                end
                ST_ADDR, ST_DATA: begin
                    if (need_word) begin
                        if (pix_valid) begin
                            stalled_q <= 1'b0;
                            if (state_q == ST_ADDR) begin
                                words_left_q <= WL_W'(WORDS - 1);
                                state_q      <= ST_DATA;
                            end else begin
                                words_left_q <= words_left_q - WL_W'(1);
                            end
                        end else begin
                            stalled_q  <= 1'b1;
                            underrun_q <= !stalled_q;
                        end
                    end else if (state_q == ST_DATA && sh_ready) begin
                        state_q <= ST_LDUMMY;
                    end
                end
                ST_LDUMMY: begin
                    if (sh_ready) begin
                        if (lines_left_q == ADDR_W'(1)) begin
                            state_q <= ST_TRAIL;
                        end else begin
                            lines_left_q <= lines_left_q - ADDR_W'(1);
                            addr_q       <= next_addr;
                            state_q      <= ST_ADDR;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (sh_ready) begin
                        cnt_q   <= '0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 16'(HOLD_CYC - 1)) begin
                        scs_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 16'(HOLD_CYC - 1)) begin
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    memlcd_bit_shifter #(
        .W       (SH_W),
        .CLK_DIV (CLK_DIV),
        .CNT_W   (NB_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .stall_i (sh_stall),
        .word_i  (sh_word),
        .nbits_i (sh_nbits),
        .ready_o (sh_ready),
        .sclk_o  (lcd_sclk),
        .si_o    (lcd_si)
    );

    assign lcd_scs   = scs_q;
    assign busy      = busy_q;
    assign cmd_ready = rdy_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_memlcd_spi_engine.sv
// Self-checking bench for memlcd_spi_engine: expected serial bits are queued
// when a command is issued and compared on each SCLK rising edge.
module tb_memlcd_spi_engine;

    localparam int unsigned LINE_PIXELS = 336;
    localparam int unsigned NUM_LINES   = 240;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned SETUP_CYC   = 8;
    localparam int unsigned HOLD_CYC    = 8;
    localparam int WORDS = LINE_PIXELS / DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_vcom;
    logic [1:0]        cmd_mode;
    logic [ADDR_W-1:0] cmd_start_line, cmd_num_lines;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid, pix_ready, busy, underrun;
    logic              lcd_sclk, lcd_si, lcd_scs;

    memlcd_spi_engine #(
        .LINE_PIXELS (LINE_PIXELS),
        .NUM_LINES   (NUM_LINES),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .CLK_DIV     (CLK_DIV),
        .SETUP_CYC   (SETUP_CYC),
        .HOLD_CYC    (HOLD_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_mode       (cmd_mode),
        .cmd_vcom       (cmd_vcom),
        .cmd_start_line (cmd_start_line),
        .cmd_num_lines  (cmd_num_lines),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .busy           (busy),
        .underrun       (underrun),
        .lcd_sclk       (lcd_sclk),
        .lcd_si         (lcd_si),
        .lcd_scs        (lcd_scs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int k);
        return ((k % 2) != 0) ? 16'h5555 : 16'hAAAA;
    endfunction

    bit exp_q[$];
    int pulses = 0, underruns = 0, word_idx = 0;
    int sclk_bad = 0, ready_bad = 0, stall_viol = 0, stall_to = 0;
    int last_gap = 0, scs_rises = 0;
    int stall_word = -1;

    // Monitor: samples on the falling clk edge, away from DUT updates.
    initial begin
        logic prev_sclk, prev_scs;
        int low_cnt;
        prev_sclk = 1'b0;
        prev_scs  = 1'b0;
        low_cnt   = 0;
        forever begin
            @(negedge clk);
            if (lcd_sclk && !prev_sclk) begin
                pulses++;
                if (!lcd_scs) sclk_bad++;
                if (exp_q.size() == 0) check("extra_sclk", 1, 0);
                else                   check("si_bit", int'(lcd_si), int'(exp_q.pop_front()));
            end
            if (underrun) underruns++;
            if (busy && cmd_ready) ready_bad++;
            if (!lcd_scs) low_cnt++;
            if (lcd_scs && !prev_scs) begin
                last_gap = low_cnt;
                scs_rises++;
            end
            if (lcd_scs) low_cnt = 0;
            prev_sclk = lcd_sclk;
            prev_scs  = lcd_scs;
        end
    end

    // Pixel source: alternating pattern, optional stall at word stall_word
    // held until the underrun is seen plus 50 cycles.
    initial begin
        int phase, cnt, ubase;
        bit pop;
        phase = 0; cnt = 0; ubase = 0;
        pix_valid = 1'b1;
        pix_data  = pat(0);
        forever begin
            @(negedge clk);
            pop = pix_ready && pix_valid;
            if (phase == 2 && (lcd_sclk !== 1'b0 || lcd_scs !== 1'b1)) stall_viol++;
            @(posedge clk);
            #1;
            if (pop) word_idx++;
            case (phase)
                0: if (stall_word >= 0 && word_idx == stall_word) begin
                    phase = 1; cnt = 0; ubase = underruns;
                end
                1: begin
                    cnt++;
                    if (underruns != ubase) begin phase = 2; cnt = 0; end
                    else if (cnt > 2000) begin stall_to++; phase = 3; end
                end
                2: begin
                    cnt++;
                    if (cnt >= 50) phase = 3;
                end
                default: ;
            endcase
            pix_valid = !(phase == 1 || phase == 2);
            pix_data  = pat(word_idx);
        end
    end

    // Reference bitstream for one command; returns bit and word counts.
    task automatic build(input int mode, input int vcom, input int start, input int n,
                         input int w0, output int nb, output int nw);
        logic [7:0] m;
        logic [DATA_W-1:0] d;
        int a, w;
        nb = 0; nw = 0;
        m = '0;
        m[0] = (mode == 0);
        m[1] = vcom[0];
        m[2] = (mode == 1);
        for (int i = 0; i < 8; i++) begin exp_q.push_back(m[i]); nb++; end
        if (mode == 0 && n > 0) begin
            a = (start == 0 || start > NUM_LINES) ? 1 : start;
            w = w0;
            for (int l = 0; l < n; l++) begin
                for (int i = 0; i < ADDR_W; i++) begin exp_q.push_back(((a >> i) & 1) != 0); nb++; end
                for (int k = 0; k < WORDS; k++) begin
                    d = pat(w);
                    w++; nw++;
                    for (int i = 0; i < DATA_W; i++) begin exp_q.push_back(d[i]); nb++; end
                end
                for (int i = 0; i < 8; i++) begin exp_q.push_back(1'b0); nb++; end
                a = (a == NUM_LINES) ? 1 : a + 1;
            end
        end
        for (int i = 0; i < 8; i++) begin exp_q.push_back(1'b0); nb++; end
    endtask

    task automatic wait_accept(input string tag);
        int k;
        bit ok;
        k = 0; ok = 1'b0;
        while (!ok && k < 200) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!ok) check({tag, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 20000);
        if (busy) check({tag, "_idle_timeout"}, 1, 0);
    endtask

    task automatic drive_cmd(input int mode, input int vcom, input int start, input int n);
        @(posedge clk);
        #1;
        cmd_mode       = 2'(mode);
        cmd_vcom       = vcom[0];
        cmd_start_line = ADDR_W'(start);
        cmd_num_lines  = ADDR_W'(n);
        cmd_valid      = 1'b1;
    endtask

    task automatic run_cmd(input string tag, input int mode, input int vcom, input int start,
                           input int n, input int exp_und);
        int p0, w0, u0, nb, nw;
        p0 = pulses; w0 = word_idx; u0 = underruns;
        build(mode, vcom, start, n, w0, nb, nw);
        drive_cmd(mode, vcom, start, n);
        wait_accept(tag);
        cmd_valid = 1'b0;
        wait_idle(tag);
        check({tag, "_pulses"}, pulses - p0, nb);
        check({tag, "_words"}, word_idx - w0, nw);
        check({tag, "_underruns"}, underruns - u0, exp_und);
        check({tag, "_bits_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int w0, k, p0, r0, nb, nw;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_mode = '0; cmd_vcom = 1'b0;
        cmd_start_line = '0; cmd_num_lines = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", int'(lcd_sclk), 0);
        check("rst_si", int'(lcd_si), 0);
        check("rst_scs", int'(lcd_scs), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pix_ready", int'(pix_ready), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        run_cmd("upd1", 0, 0, 5, 1, 0);
        run_cmd("clear", 1, 1, 0, 0, 0);
        run_cmd("wrap", 0, 0, 240, 2, 0);
        run_cmd("upd0", 0, 1, 7, 0, 0);
        run_cmd("rsvd", 3, 0, 9, 4, 0);

        stall_word = word_idx + 3;
        run_cmd("stall", 0, 0, 5, 1, 1);
        check("stall_pins", stall_viol, 0);
        check("stall_timeout", stall_to, 0);

        // Reset in the middle of the pixel field.
        w0 = word_idx;
        build(0, 0, 10, 1, w0, nb, nw);
        drive_cmd(0, 0, 10, 1);
        wait_accept("rstmid");
        cmd_valid = 1'b0;
        k = 0;
        while (word_idx < w0 + 5 && k < 5000) begin @(negedge clk); k++; end
        check("rstmid_reached_data", int'(word_idx >= w0 + 5), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_scs", int'(lcd_scs), 0);
        check("rstmid_sclk", int'(lcd_sclk), 0);
        check("rstmid_si", int'(lcd_si), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_cmd_ready", int'(cmd_ready), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        run_cmd("clear_after_rst", 1, 0, 0, 0, 0);

        // Back-to-back VCOM-only with cmd_valid held high.
        p0 = pulses; r0 = scs_rises;
        build(2, 1, 0, 0, word_idx, nb, nw);
        build(2, 1, 0, 0, word_idx, nb, nw);
        drive_cmd(2, 1, 0, 0);
        k = 0;
        while (scs_rises < r0 + 2 && k < 5000) begin @(negedge clk); k++; end
        check("b2b_second_start", scs_rises - r0, 2);
        check("b2b_gap_ok", int'(last_gap >= HOLD_CYC), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_idle("b2b");
        check("b2b_pulses", pulses - p0, 32);
        check("b2b_bits_left", exp_q.size(), 0);
        check("b2b_transfers", scs_rises - r0, 2);

        check("sclk_outside_scs", sclk_bad, 0);
        check("cmd_ready_while_busy", ready_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
